// File: rtl/nios_mul_arbiter.sv
// nios_mul_arbiter: round-robin front end that shares one pipelined 32x32
// low-word multiplier cell between NUM_REQ requesters. Grants at most one
// operation per cycle, steers the granted operands onto the cell, and follows
// each operation through a tag pipe so the product returns to its issuer.
`timescale 1ns/1ps
module nios_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_src1,
  input  logic [NUM_REQ*32-1:0]  req_src2,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            mul_src1,
  output logic [31:0]            mul_src2,
  input  logic [31:0]            mul_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_result,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Round-robin pointer: index of the most recently granted requester.
  logic [IDX_W-1:0] rr_ptr_r;

  // Arbitration results for the current cycle.
  logic             grant_vld_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             cand_hit_s;

  // Operands unpacked per requester for a clean indexed mux.
  logic [31:0] src1_arr_s [NUM_REQ];
  logic [31:0] src2_arr_s [NUM_REQ];

  // Tag pipe: one {valid, index} entry per multiplier stage.
  logic [MUL_LATENCY-1:0] tag_vld_r;
  logic [IDX_W-1:0]       tag_idx_r [MUL_LATENCY];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign src1_arr_s[g] = req_src1[32*g +: 32];
    assign src2_arr_s[g] = req_src2[32*g +: 32];
  end

  // Scan upward from the slot after rr_ptr and take the first valid request.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_idx_s  = '0;
    cand_hit_s  = 1'b0;
    if (arb_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand_idx_s  = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
        cand_hit_s  = !grant_vld_s && req_valid[cand_idx_s];
        grant_idx_s = cand_hit_s ? cand_idx_s : grant_idx_s;
        grant_vld_s = grant_vld_s | cand_hit_s;
      end
    end else begin
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
    end
  end

  // One-hot grant and operand steering; operands park at zero when idle.
  always_comb begin
    req_ready = '0;
    mul_src1  = 32'h0;
    mul_src2  = 32'h0;
    if (grant_vld_s) begin
      req_ready[grant_idx_s] = 1'b1;
      mul_src1 = src1_arr_s[grant_idx_s];
      mul_src2 = src2_arr_s[grant_idx_s];
    end else begin
      req_ready = '0;
      mul_src1  = 32'h0;
      mul_src2  = 32'h0;
    end
  end

  // Advance the round-robin pointer only when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= LAST_IDX;
    end else if (grant_vld_s) begin
      rr_ptr_r <= grant_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Tag pipe shifts every cycle in lockstep with the stall-free cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_r <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_idx_r[i] <= '0;
      end
    end else begin
      tag_vld_r[0] <= grant_vld_s;
      tag_idx_r[0] <= grant_idx_s;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
    end
  end

  // Route the cell output to the issuer named by the oldest tag.
  always_comb begin
    rsp_valid  = '0;
    rsp_result = 32'h0;
    if (tag_vld_r[MUL_LATENCY-1]) begin
      rsp_valid[tag_idx_r[MUL_LATENCY-1]] = 1'b1;
      rsp_result = mul_result;
    end else begin
      rsp_valid  = '0;
      rsp_result = 32'h0;
    end
  end

  assign busy = |tag_vld_r;

endmodule

// File: tb/tb_nios_mul_arbiter.sv
// Scoreboard bench for nios_mul_arbiter: a stimulus process predicts grants and
// products from the round-robin rule and queues expected responses; a monitor
// process pops and compares whenever the response port is sampled.
`timescale 1ns/1ps
module tb_nios_mul_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             arb_en = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*32-1:0]  req_src1 = '0;
  logic [N*32-1:0]  req_src2 = '0;
  logic [N-1:0]     req_ready;
  logic [31:0]      mul_src1;
  logic [31:0]      mul_src2;
  logic [31:0]      mul_result;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_result;
  logic             busy;

  nios_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en),
    .req_valid(req_valid), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier cell: LAT-stage delay line of low-word products.
  logic [31:0] cell_pipe [LAT];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int i = 1; i < LAT; i++) cell_pipe[i] <= cell_pipe[i-1];
  end
  assign mul_result = cell_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] prod;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = N - 1;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [N*32-1:0] at(input int i, input logic [31:0] v);
    logic [N*32-1:0] r;
    r = '0;
    r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic logic [N*32-1:0] rnd();
    logic [N*32-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       r[32*i +: 32] = 32'hFFFF_FFFF;
        1:       r[32*i +: 32] = 32'h0;
        2:       r[32*i +: 32] = 32'h0001_0000;
        default: r[32*i +: 32] = $urandom;
      endcase
    end
    return r;
  endfunction

  // One cycle of stimulus; predicted grant is checked and its result queued.
  task automatic step(input logic en, input logic [N-1:0] v,
                      input logic [N*32-1:0] s1, input logic [N*32-1:0] s2);
    int g;
    logic [31:0] a;
    logic [31:0] b;
    @(posedge clk);
    #1;
    arb_en = en; req_valid = v; req_src1 = s1; req_src2 = s2;
    @(negedge clk);
    g = -1;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && v[(rr_m + k) % N]) g = (rr_m + k) % N;
      end
    end
    a = 32'h0;
    b = 32'h0;
    if (g >= 0) begin
      a = s1[32*g +: 32];
      b = s2[32*g +: 32];
    end
    check32("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check32("mul_src1", mul_src1, a);
    check32("mul_src2", mul_src2, b);
    if (g >= 0) begin
      rr_m = g;
      q.push_back(exp_t'{cyc + LAT, g, a * b});
    end
  endtask

  // Monitor: every cycle, compare the response port and busy against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      check32("busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() > 0 && q[0].due == cyc) begin
        check32("rsp_valid", 32'(rsp_valid), 32'd1 << q[0].idx);
        check32("rsp_result", rsp_result, q[0].prod);
        void'(q.pop_front());
      end else begin
        check32("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        check32("rsp_result_idle", rsp_result, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_req_ready", 32'(req_ready), 32'd0);
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_mul_src1", mul_src1, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Single op from requester 0: 7 * 6
    step(1'b1, 4'b0001, at(0, 32'd7), at(0, 32'd6));
    repeat (LAT + 1) step(1'b1, 4'b0000, '0, '0);

    // All requesters valid: rotating grants, one result per cycle
    repeat (8) step(1'b1, 4'b1111, rnd(), rnd());
    repeat (LAT) step(1'b1, 4'b0000, '0, '0);

    // Wrap-around operands
    step(1'b1, 4'b0010, at(1, 32'hFFFF_FFFF), at(1, 32'h2));
    step(1'b1, 4'b1000, at(3, 32'h0001_0000), at(3, 32'h0001_0000));

    // Back-to-back ops from requester 2 return in issue order
    repeat (3) step(1'b1, 4'b0100, rnd(), rnd());
    repeat (LAT + 1) step(1'b1, 4'b0000, '0, '0);

    // arb_en low with requests pending: no grants, pipe still drains
    step(1'b1, 4'b0001, rnd(), rnd());
    repeat (LAT + 2) step(1'b0, 4'b1111, rnd(), rnd());
    step(1'b1, 4'b1111, rnd(), rnd());
    repeat (LAT + 1) step(1'b1, 4'b0000, '0, '0);

    // Reset half a cycle after a grant: op is dropped, pointer reinitialised
    step(1'b1, 4'b1100, rnd(), rnd());
    step(1'b1, 4'b0100, rnd(), rnd());
    reset = 1'b1;
    q.delete();
    rr_m = N - 1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    step(1'b1, 4'b1111, rnd(), rnd());
    repeat (LAT + 1) step(1'b1, 4'b0000, '0, '0);

    // Randomised traffic
    repeat (400) step(1'($urandom_range(0, 9) != 0), N'($urandom), rnd(), rnd());

    // Drain and confirm every expected response was seen
    repeat (LAT + 2) step(1'b1, 4'b0000, '0, '0);
    check32("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
